// File: rtl/lt24_pll_lock_supervisor.sv
// rtl/lt24_pll_lock_supervisor.sv - PLL reset sequencer, lock debouncer and downstream reset generator
//
// Holds the PLL in reset for a fixed interval and waits for lock. If lock does not
// arrive in time, it counts a timeout and retries. It releases the active-low
// downstream reset only after lock has held for STABLE_CYCLES cycles.
//
// Ports:
//   clk             in   reference clock (same clock as the PLL refclk)
//   reset_n         in   asynchronous active-low reset
//   locked          in   PLL lock indicator, asynchronous to clk
//   restart         in   single-cycle request to re-run the PLL reset sequence
//   pll_rst         out  active-high PLL reset
//   reset_out_n     out  active-low reset for the PLL-clock domain
//   lock_ok         out  high only while in RUN
//   lock_loss_count out  saturating count of lock losses seen in RUN
//   timeout_count   out  saturating count of lock-wait timeouts
//   state           out  current state (0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN)

module lt24_pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       reset_out_n,
    output logic       lock_ok,
    output logic [7:0] lock_loss_count,
    output logic [7:0] timeout_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_locked_m;
    logic             r_locked_s;
    logic             r_pll_rst;
    logic             r_reset_out_n;
    logic             r_lock_ok;
    logic [7:0]       r_lock_loss_count;
    logic [7:0]       r_timeout_count;
    logic             w_loss_evt;
    logic             w_timeout_evt;
    logic             w_cnt_clr;

    // Two-flop synchronizer; only r_locked_s feeds decisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_locked_m <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_locked_m <= locked;
            r_locked_s <= r_locked_m;
        end
    end

    // Next-state logic. restart overrides everything, including event counting.
    always_comb begin
        w_state_nxt   = r_state;
        w_loss_evt    = 1'b0;
        w_timeout_evt = 1'b0;
        if (restart) begin
            w_state_nxt = RESET_PLL;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_cnt == L_RST_LAST) begin
                        w_state_nxt = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes precedence over a coincident timeout.
                    if (r_locked_s) begin
                        w_state_nxt = STABILIZE;
                    end else if (r_cnt == L_TIMEOUT_LAST) begin
                        w_state_nxt   = RESET_PLL;
                        w_timeout_evt = 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!r_locked_s) begin
                        w_state_nxt = WAIT_LOCK;
                    end else if (r_cnt == L_STABLE_LAST) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    // The PLL relocks by itself, so go back to waiting rather than resetting it.
                    if (!r_locked_s) begin
                        w_state_nxt = WAIT_LOCK;
                        w_loss_evt  = 1'b1;
                    end
                end
                default: w_state_nxt = RESET_PLL;
            endcase
        end
    end

    // restart in RESET_PLL keeps the state but still restarts the hold interval.
    assign w_cnt_clr = restart || (w_state_nxt != r_state);

    // Outputs decode from the next state so they switch on the same edge as state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= RESET_PLL;
            r_cnt             <= '0;
            r_pll_rst         <= 1'b1;
            r_reset_out_n     <= 1'b0;
            r_lock_ok         <= 1'b0;
            r_lock_loss_count <= 8'd0;
            r_timeout_count   <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_pll_rst     <= (w_state_nxt == RESET_PLL);
            r_reset_out_n <= (w_state_nxt == RUN);
            r_lock_ok     <= (w_state_nxt == RUN);
            if (w_loss_evt && (r_lock_loss_count != 8'hFF)) begin
                r_lock_loss_count <= r_lock_loss_count + 8'd1;
            end
            if (w_timeout_evt && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    assign pll_rst         = r_pll_rst;
    assign reset_out_n     = r_reset_out_n;
    assign lock_ok         = r_lock_ok;
    assign lock_loss_count = r_lock_loss_count;
    assign timeout_count   = r_timeout_count;
    assign state           = r_state;

endmodule

// File: tb/tb_lt24_pll_lock_supervisor.sv
// tb/tb_lt24_pll_lock_supervisor.sv - directed table-driven bench for lt24_pll_lock_supervisor

module tb_lt24_pll_lock_supervisor;

    logic       clk;
    logic       reset_n;
    logic       locked;
    logic       restart;
    logic       pll_rst;
    logic       reset_out_n;
    logic       lock_ok;
    logic [7:0] lock_loss_count;
    logic [7:0] timeout_count;
    logic [1:0] state;

    int n_total;
    int n_pass;

    lt24_pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (10),
        .CNT_W         (17)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .locked         (locked),
        .restart        (restart),
        .pll_rst        (pll_rst),
        .reset_out_n    (reset_out_n),
        .lock_ok        (lock_ok),
        .lock_loss_count(lock_loss_count),
        .timeout_count  (timeout_count),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lk;
        logic       rs;
        int         n;
        logic [1:0] st;
        logic       pr;
        logic       ro;
        logic       ok;
        logic [7:0] llc;
        logic [7:0] toc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic lk, input logic rs, input int n, input logic [1:0] st,
                       input logic pr, input logic ro, input logic ok,
                       input logic [7:0] llc, input logic [7:0] toc);
        vec_t v;
        v.lk = lk; v.rs = rs; v.n = n; v.st = st; v.pr = pr;
        v.ro = ro; v.ok = ok; v.llc = llc; v.toc = toc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, state, 0);
        chk({tag, ".pll_rst"}, pll_rst, 1);
        chk({tag, ".reset_out_n"}, reset_out_n, 0);
        chk({tag, ".lock_ok"}, lock_ok, 0);
        chk({tag, ".lock_loss_count"}, lock_loss_count, 0);
        chk({tag, ".timeout_count"}, timeout_count, 0);
    endtask

    // Leaves the bench one time unit after the edge at which reset_n rises (edge 0).
    task automatic do_reset();
        reset_n = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int rises[4];
        int n_rise;
        int highs;
        logic prev;
        logic ro_seen;

        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;

        // Reset values while reset_n is held low
        tick(2);
        chk_reset_vals("rst");

        // lk rs  n  st pr ro ok llc toc
        add(0, 0, 3,  0, 1, 0, 0, 0, 0);   // still holding PLL reset after 3 edges
        add(0, 0, 1,  1, 0, 0, 0, 0, 0);   // pll_rst falls on edge 4
        add(0, 0, 16, 1, 0, 0, 0, 0, 0);   // 20 edges after release
        add(1, 0, 2,  1, 0, 0, 0, 0, 0);   // synchronizer latency
        add(1, 0, 1,  2, 0, 0, 0, 0, 0);   // STABILIZE 3 edges after lock
        add(1, 0, 9,  2, 0, 0, 0, 0, 0);
        add(1, 0, 1,  3, 0, 1, 1, 0, 0);   // release 13 edges after lock
        add(0, 0, 2,  3, 0, 1, 1, 0, 0);   // loss not yet seen
        add(0, 0, 1,  1, 0, 0, 0, 1, 0);   // reset_out_n low 3 edges after drop, count updates
        add(0, 0, 2,  1, 0, 0, 0, 1, 0);   // no PLL reset during the 5-cycle drop
        add(1, 0, 12, 2, 0, 0, 0, 1, 0);
        add(1, 0, 1,  3, 0, 1, 1, 1, 0);   // release 13 edges after restore
        add(0, 0, 3,  1, 0, 0, 0, 2, 0);   // second loss
        add(1, 0, 3,  2, 0, 0, 0, 2, 0);   // STABILIZE, cnt=0
        add(1, 0, 7,  2, 0, 0, 0, 2, 0);   // cnt=7
        add(0, 0, 2,  2, 0, 0, 0, 2, 0);   // glitch not yet synchronized
        add(0, 0, 1,  1, 0, 0, 0, 2, 0);   // back to WAIT_LOCK, no loss counted
        add(1, 0, 2,  1, 0, 0, 0, 2, 0);
        add(1, 0, 1,  2, 0, 0, 0, 2, 0);
        add(1, 0, 9,  2, 0, 0, 0, 2, 0);   // full stabilize interval again
        add(1, 0, 1,  3, 0, 1, 1, 2, 0);
        add(1, 1, 1,  0, 1, 0, 0, 2, 0);   // restart in RUN
        add(1, 0, 2,  0, 1, 0, 0, 2, 0);
        add(1, 1, 1,  0, 1, 0, 0, 2, 0);   // restart in RESET_PLL restarts hold
        add(1, 0, 3,  0, 1, 0, 0, 2, 0);
        add(1, 0, 1,  1, 0, 0, 0, 2, 0);
        add(1, 0, 1,  2, 0, 0, 0, 2, 0);
        add(1, 0, 9,  2, 0, 0, 0, 2, 0);
        add(1, 0, 1,  3, 0, 1, 1, 2, 0);

        do_reset();
        foreach (tbl[i]) begin
            locked  = tbl[i].lk;
            restart = tbl[i].rs;
            tick(tbl[i].n);
            chk($sformatf("v%0d.state", i), state, tbl[i].st);
            chk($sformatf("v%0d.pll_rst", i), pll_rst, tbl[i].pr);
            chk($sformatf("v%0d.reset_out_n", i), reset_out_n, tbl[i].ro);
            chk($sformatf("v%0d.lock_ok", i), lock_ok, tbl[i].ok);
            chk($sformatf("v%0d.llc", i), lock_loss_count, tbl[i].llc);
            chk($sformatf("v%0d.toc", i), timeout_count, tbl[i].toc);
        end
        restart = 1'b0;

        // Lock never arrives: retries every 104 edges
        do_reset();
        n_rise = 0; highs = 0; prev = 1'b1; ro_seen = 1'b0;
        for (int i = 1; i <= 350; i++) begin
            tick(1);
            if (pll_rst && !prev && n_rise < 4) begin
                rises[n_rise] = i;
                n_rise++;
            end
            if (pll_rst) highs++;
            if (reset_out_n) ro_seen = 1'b1;
            prev = pll_rst;
        end
        chk("to.rises", n_rise, 3);
        chk("to.rise0", rises[0], 104);
        chk("to.gap1", rises[1] - rises[0], 104);
        chk("to.gap2", rises[2] - rises[1], 104);
        chk("to.pll_high_cycles", highs, 15);
        chk("to.reset_out_seen", ro_seen, 0);
        chk("to.timeout_count", timeout_count, 3);

        // Lock synchronized on the same edge as the timeout: lock wins
        do_reset();
        tick(101);
        locked = 1'b1;
        tick(2);
        chk("tie.state_before", state, 1);
        tick(1);
        chk("tie.state", state, 2);
        chk("tie.timeout_count", timeout_count, 0);
        chk("tie.pll_rst", pll_rst, 0);

        // Lock-loss counter saturation
        do_reset();
        locked = 1'b1;
        tick(20);
        chk("sat.run", state, 3);
        for (int i = 0; i < 260; i++) begin
            locked = 1'b0;
            tick(3);
            locked = 1'b1;
            tick(14);
            if (i == 254) chk("sat.llc255", lock_loss_count, 255);
        end
        chk("sat.llc_hold", lock_loss_count, 255);
        chk("sat.state", state, 3);
        chk("sat.toc", timeout_count, 0);

        // Asynchronous reset in WAIT_LOCK, between clock edges
        locked = 1'b0;
        tick(3);
        chk("ar.wait", state, 1);
        chk("ar.llc_pre", lock_loss_count, 255);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        tick(2);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
